jk_register_array: RTL and testbench



---
 rtl/jk_register_array.sv | 95 +++++++++
 tb/tb_jk_register_array.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/jk_register_array.sv
// Bank of WIDTH JK-style cells usable as JK register, parallel-load D register, toggle register or up-counter.
// Optional `changed` output is enabled by defining JK_REGISTER_ARRAY_CHANGE_FLAG_EN.
module jk_register_array #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
`ifdef JK_REGISTER_ARRAY_CHANGE_FLAG_EN
    output logic             changed,
`endif
    output logic             tc
);

    localparam logic [1:0] MODE_JK     = 2'b00;
    localparam logic [1:0] MODE_LOAD   = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_q_bar;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_count_toggle;

    // Toggle enables of a synchronous counter: bit i toggles when all lower bits are 1.
    function automatic logic [WIDTH-1:0] count_toggles(input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] t;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & cur[i-1];
        end
        return t;
    endfunction

    // Characteristic JK equation: q+ = j&~q | ~k&q, applied bitwise.
    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] jv,
                                                 input logic [WIDTH-1:0] kv);
        return (jv & ~cur) | (~kv & cur);
    endfunction

    // Next-state selection per mode; hold whenever the enable is low.
    always_comb begin
        w_count_toggle = count_toggles(r_q);
        w_next         = r_q;
        if (en) begin
            case (mode)
                MODE_JK:     w_next = jk_next(r_q, j, k);
                MODE_LOAD:   w_next = j;
                MODE_TOGGLE: w_next = r_q ^ j;
                MODE_COUNT:  w_next = r_q ^ w_count_toggle;
                default:     w_next = r_q;
            endcase
        end else begin
            w_next = r_q;
        end
    end

    // State register; q_bar is loaded from the same next value so it never lags q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= RESET_VAL;
            r_q_bar <= ~RESET_VAL;
        end else begin
            r_q     <= w_next;
            r_q_bar <= ~w_next;
        end
    end

`ifdef JK_REGISTER_ARRAY_CHANGE_FLAG_EN
    logic r_changed;

    // Flags edges where the stored value actually moved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= (w_next != r_q);
        end
    end

    assign changed = r_changed;
`endif

    assign q     = r_q;
    assign q_bar = r_q_bar;
    assign tc    = (mode == MODE_COUNT) && en && (&r_q);

endmodule

// File: tb/tb_jk_register_array.sv
// Self-checking bench for jk_register_array: directed steps plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_jk_register_array;

    localparam int         W    = 4;
    localparam logic [3:0] RVAL = 4'b1010;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic         tc;
`ifdef JK_REGISTER_ARRAY_CHANGE_FLAG_EN
    logic         changed;
    logic         m_changed;
`endif

    int checks   = 0;
    int failures = 0;
    int m_q;

    jk_register_array #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .j     (j),
        .k     (k),
        .q     (q),
        .q_bar (q_bar),
`ifdef JK_REGISTER_ARRAY_CHANGE_FLAG_EN
        .changed(changed),
`endif
        .tc    (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written straight from the mode table, using integers.
    function automatic int model_next(input int cur, input logic r, input logic e,
                                      input logic [1:0] md, input logic [3:0] jv, input logic [3:0] kv);
        int nq;
        if (!r) return int'(RVAL);
        if (!e) return cur;
        nq = cur;
        if (md == 2'd0) begin
            for (int i = 0; i < W; i++) begin
                if (jv[i] && !kv[i])      nq = nq | (1 << i);
                else if (!jv[i] && kv[i]) nq = nq & ~(1 << i);
                else if (jv[i] && kv[i])  nq = nq ^ (1 << i);
            end
        end else if (md == 2'd1) nq = int'(jv);
        else if (md == 2'd2)     nq = cur ^ int'(jv);
        else                     nq = (cur + 1) % 16;
        return nq;
    endfunction

    // Drive one edge's inputs, advance the model, then check outputs on the falling edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [1:0] md, input logic [3:0] jv, input logic [3:0] kv);
        int nq;
        rst_n = r; en = e; mode = md; j = jv; k = kv;
        nq = model_next(m_q, r, e, md, jv, kv);
`ifdef JK_REGISTER_ARRAY_CHANGE_FLAG_EN
        m_changed = r && (nq != m_q);
`endif
        m_q = nq;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".q"},     32'(q),     32'(m_q));
        check({tag, ".q_bar"}, 32'(q_bar), 32'((~m_q) & 15));
        check({tag, ".tc"},    32'(tc),    32'((md == 2'd3) && e && (m_q == 15)));
`ifdef JK_REGISTER_ARRAY_CHANGE_FLAG_EN
        check({tag, ".changed"}, 32'(changed), 32'(m_changed));
`endif
    endtask

    initial begin
        m_q = 0;
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; j = 4'h0; k = 4'h0;

        step("rst_en1", 1'b0, 1'b1, 2'b11, 4'hF, 4'hF);
        check("rst_en1.q_const", 32'(q), 32'h0000_000A);
        check("rst_en1.qb_const", 32'(q_bar), 32'h0000_0005);
        step("rst_en0", 1'b0, 1'b0, 2'b11, 4'h3, 4'h3);
        check("rst_en0.q_const", 32'(q), 32'h0000_000A);

        step("jk_clr", 1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        step("jk_e1", 1'b1, 1'b1, 2'b00, 4'b1100, 4'b0101);
        check("jk_e1.q_const", 32'(q), 32'h0000_000C);
        check("jk_e1.qb_const", 32'(q_bar), 32'h0000_0003);
        step("jk_e2", 1'b1, 1'b1, 2'b00, 4'b1100, 4'b0101);
        check("jk_e2.q_const", 32'(q), 32'h0000_0008);
        check("jk_e2.qb_const", 32'(q_bar), 32'h0000_0007);

        step("load", 1'b1, 1'b1, 2'b01, 4'b0110, 4'b1111);
        check("load.q_const", 32'(q), 32'h0000_0006);
        step("toggle", 1'b1, 1'b1, 2'b10, 4'b0011, 4'b1111);
        check("toggle.q_const", 32'(q), 32'h0000_0005);
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 2'b01, 4'b1111, 4'b0000);
        check("hold.q_const", 32'(q), 32'h0000_0005);

        step("cnt_clr", 1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        for (int i = 0; i < 15; i++) step("count", 1'b1, 1'b1, 2'b11, 4'($urandom), 4'($urandom));
        check("count15.q_const", 32'(q), 32'h0000_000F);
        check("count15.tc_const", 32'(tc), 32'h0000_0001);
        step("wrap", 1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        check("wrap.q_const", 32'(q), 32'h0000_0000);
        check("wrap.tc_const", 32'(tc), 32'h0000_0000);
        for (int i = 0; i < 7; i++) step("count7", 1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        for (int i = 0; i < 2; i++) step("cnt_hold", 1'b1, 1'b0, 2'b11, 4'hF, 4'hF);
        check("cnt_hold.q_const", 32'(q), 32'h0000_0007);
        check("cnt_hold.tc_const", 32'(tc), 32'h0000_0000);

        step("mid_clr", 1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) step("mid_cnt", 1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        check("mid_cnt.q_const", 32'(q), 32'h0000_0005);
        step("mid_rst", 1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
        check("mid_rst.q_const", 32'(q), 32'h0000_000A);
        step("mid_resume", 1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        check("mid_resume.q_const", 32'(q), 32'h0000_000B);

`ifdef JK_REGISTER_ARRAY_CHANGE_FLAG_EN
        step("chg_pre", 1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        step("chg_e1", 1'b1, 1'b1, 2'b01, 4'b0011, 4'b0000);
        check("chg_e1.const", 32'(changed), 32'h0000_0001);
        step("chg_e2", 1'b1, 1'b1, 2'b01, 4'b0011, 4'b0000);
        check("chg_e2.const", 32'(changed), 32'h0000_0000);
        step("chg_rst", 1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000);
        check("chg_rst.const", 32'(changed), 32'h0000_0000);
`endif

        for (int n = 0; n < 300; n++) begin
            step("rand", 1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0),
                 2'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
